// File: rtl/matrix_collector_pkg.sv
// -----------------------------------------------------------------------------
// matrix_collector_pkg
// Declarations shared by the matrix collector and the input-side skew feeder.
// This file has no ports. It provides:
//   N_DEFAULT, W_DEFAULT : default matrix dimension and element width
//   state_t              : collector FSM states (IDLE / COLLECT)
//   beat_cnt_width()     : width of a counter spanning the 2N-1 beats of a frame
// -----------------------------------------------------------------------------
package matrix_collector_pkg;

  localparam int N_DEFAULT = 32;
  localparam int W_DEFAULT = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Returns ceil(log2(2n-1)). The result is kept at a minimum of 1 so that a
  // degenerate N=1 build still has a legal counter vector.
  function automatic int beat_cnt_width(input int n);
    int beats;
    beats = 2 * n - 1;
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/collector_ctrl.sv
// -----------------------------------------------------------------------------
// collector_ctrl
// Frame sequencer for matrix_collector. It holds the IDLE/COLLECT FSM and the
// beat counter, and it generates the busy level and the done pulse.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   en         : global enable; when low, all state holds and done is masked
//   valid_in   : the current input beat is valid
//   accept     : a beat is taken at this edge (en & valid_in)
//   last_beat  : the accepted beat is the final one, t = 2N-2
//   beat       : index t of the beat currently presented
//   busy       : the FSM is in COLLECT
//   done       : one-cycle pulse in the cycle after the final beat
// -----------------------------------------------------------------------------
module collector_ctrl
  import matrix_collector_pkg::*;
#(
  parameter  int N  = N_DEFAULT,
  localparam int CW = beat_cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          valid_in,
  output logic          accept,
  output logic          last_beat,
  output logic [CW-1:0] beat,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(2 * N - 2);

  state_t state;
  state_t next_state;
  logic   done_q;

  // State register, beat counter and done flop.
  // NOTE: sequential state uses non-blocking (<=) assignments so that every
  // flop samples values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      beat   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= last_beat;
      if (accept) begin
        beat <= last_beat ? '0 : beat + 1'b1;
      end
    end
  end

  // Next-state logic. A valid_in=0 cycle in COLLECT is a stall, so the FSM
  // leaves COLLECT only on the final beat.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept && !last_beat) next_state = COLLECT;
      COLLECT: if (last_beat)            next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    accept    = en & valid_in;
    last_beat = accept & (beat == LAST_BEAT);
    busy      = (state == COLLECT);
    // done is masked whenever en is low.
    done      = done_q & en;
  end

endmodule

// File: rtl/matrix_collector.sv
// -----------------------------------------------------------------------------
// matrix_collector
// Removes the diagonal skew from a systolic feeder. On beat t, lane i carries
// element [t-i][i]. The module collects the 2N-1 beats of a frame into a
// buffer. When the frame completes, it copies the full buffer to matrix_out.
// Optional build macro:
//   MATRIX_COLLECTOR_FRAME_CNT_EN : adds frame_cnt, a wrapping 16-bit count
//                                   of completed frames
// Ports:
//   clk, rst_n : clock and synchronous active-low reset (takes precedence over en)
//   en         : global enable; when low, all state holds and done is 0
//   valid_in   : vector_in carries one skewed beat
//   vector_in  : N lanes of W bits; lane i is vector_in[i]
//   busy       : a frame is partially collected
//   done       : one-cycle pulse in the cycle after matrix_out is updated
//   matrix_out : last completed matrix, indexed [row][col]; held stable
//   frame_cnt  : (optional) number of completed frames
// -----------------------------------------------------------------------------
module matrix_collector
  import matrix_collector_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        valid_in,
  input  logic [N-1:0][W-1:0]         vector_in,
  output logic                        busy,
  output logic                        done,
  output logic [N-1:0][N-1:0][W-1:0]  matrix_out
`ifdef MATRIX_COLLECTOR_FRAME_CNT_EN
  ,
  output logic [15:0]                 frame_cnt
`endif
);

  localparam int CW = beat_cnt_width(N);

  logic                       accept;
  logic                       last_beat;
  logic [CW-1:0]              beat;
  logic [N-1:0][N-1:0][W-1:0] frame_buf;

  collector_ctrl #(.N(N)) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .valid_in  (valid_in),
    .accept    (accept),
    .last_beat (last_beat),
    .beat      (beat),
    .busy      (busy),
    .done      (done)
  );

  // Deskew write. Element [r][c] arrives on lane c at beat r+c. Lanes whose
  // row r = t-c falls outside 0..N-1 match no element and are dropped.
  // NOTE: frame_buf has no reset. Every element is written before it is
  // copied out, so a reset would only add fan-out to a large array.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (int'(beat) == r + c) frame_buf[r][c] <= vector_in[c];
        end
      end
    end
  end

  // Frame copy. Elements written on the final beat (only [N-1][N-1]) are taken
  // straight from the lane, because frame_buf does not hold them yet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      matrix_out <= '0;
    end else if (last_beat) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          matrix_out[r][c] <= (int'(beat) == r + c) ? vector_in[c] : frame_buf[r][c];
        end
      end
    end
  end

`ifdef MATRIX_COLLECTOR_FRAME_CNT_EN
  // Increments on the final-beat edge, so frame_cnt changes in the same cycle
  // that done rises. It wraps naturally from 0xFFFF to 0.
  always_ff @(posedge clk) begin
    if (!rst_n)         frame_cnt <= '0;
    else if (last_beat) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_matrix_collector.sv
// -----------------------------------------------------------------------------
// tb_matrix_collector
// Self-checking bench for matrix_collector at N=32, W=16. The source matrix is
// M[r][c] = r*32 + c + 1 + offset. It is skewed so that lane i carries
// M[t-i][i] on beat t. A reference table of hand-computed elements is checked
// after the nominal frame. Hand-written sequences cover the following cases:
// stalls, back-to-back frames, enable gating, reset mid-frame, and the
// optional frame counter.
// -----------------------------------------------------------------------------
module tb_matrix_collector;

  localparam int N     = 32;
  localparam int W     = 16;
  localparam int LAST  = 2 * N - 2;
  localparam int NONE  = -1;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       en;
  logic                       valid_in;
  logic [N-1:0][W-1:0]        vector_in;
  logic                       busy;
  logic                       done;
  logic [N-1:0][N-1:0][W-1:0] matrix_out;
`ifdef MATRIX_COLLECTOR_FRAME_CNT_EN
  logic [15:0]                frame_cnt;
`endif

  matrix_collector #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .valid_in   (valid_in),
    .vector_in  (vector_in),
    .busy       (busy),
    .done       (done),
    .matrix_out (matrix_out)
`ifdef MATRIX_COLLECTOR_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Cycle index. The value read after an edge is that edge's number.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Records the edge number at which each done pulse was launched.
  // done is sampled at the negedge, away from the active edge.
  int done_hist[$];
  always @(negedge clk) if (done === 1'b1) done_hist.push_back(cyc);

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int m_val(input int r, input int c, input int offset);
    return r * 32 + c + 1 + offset;
  endfunction

  function automatic logic [N-1:0][W-1:0] beat_vec(input int t, input int offset);
    logic [N-1:0][W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (t - i >= 0 && t - i <= N - 1) v[i] = W'(m_val(t - i, i, offset));
    end
    return v;
  endfunction

  function automatic int mat_errors(input int offset);
    int e = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (matrix_out[r][c] !== W'(m_val(r, c, offset))) e++;
    return e;
  endfunction

  function automatic int nonzero_count();
    int e = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (matrix_out[r][c] !== '0) e++;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int t, input int offset);
    en        = 1'b1;
    valid_in  = 1'b1;
    vector_in = beat_vec(t, offset);
    step();
  endtask

  task automatic idle_cycle();
    en        = 1'b1;
    valid_in  = 1'b0;
    vector_in = '0;
    step();
  endtask

  // Sends one frame. It can insert 3-cycle stalls after beats stall_a and
  // stall_b, and a 5-cycle en=0 window after beat gate_at. The window carries
  // valid_in=1 and 0xDEAD garbage data. The edge numbers of beat 0 and of the
  // final beat are returned.
  task automatic run_frame(input int offset, input int stall_a, input int stall_b,
                           input int gate_at, output int start_cyc, output int end_cyc);
    int hist0;
    start_cyc = 0;
    for (int t = 0; t <= LAST; t++) begin
      send_beat(t, offset);
      if (t == 0) start_cyc = cyc;
      if (t == stall_a || t == stall_b) begin
        for (int s = 0; s < 3; s++) begin
          idle_cycle();
          check("stall_busy", busy, 1);
        end
      end
      if (t == gate_at) begin
        hist0 = done_hist.size();
        for (int g = 0; g < 5; g++) begin
          en        = 1'b0;
          valid_in  = 1'b1;
          vector_in = {N{16'hDEAD}};
          step();
          check("gate_done_low", done, 0);
          check("gate_busy", busy, 1);
        end
        check("gate_no_done_pulse", done_hist.size(), hist0);
      end
    end
    end_cyc   = cyc;
    valid_in  = 1'b0;
    vector_in = '0;
  endtask

  typedef struct {
    int          row;
    int          col;
    logic [15:0] expected;
  } elem_vec_t;

  elem_vec_t elem_tab[7];

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, e0, s1, e1, nd;

    // Hand-computed elements of M (offset 0): r*32 + c + 1.
    elem_tab[0] = '{row: 0,  col: 0,  expected: 16'd1};
    elem_tab[1] = '{row: 31, col: 31, expected: 16'd1024};
    elem_tab[2] = '{row: 5,  col: 7,  expected: 16'd168};
    elem_tab[3] = '{row: 31, col: 0,  expected: 16'd993};
    elem_tab[4] = '{row: 0,  col: 31, expected: 16'd32};
    elem_tab[5] = '{row: 17, col: 3,  expected: 16'd548};
    elem_tab[6] = '{row: 30, col: 31, expected: 16'd992};

    // ---- Reset state ----
    rst_n = 1'b0; en = 1'b1; valid_in = 1'b0; vector_in = '0;
    step(); step();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_matrix_nonzero", nonzero_count(), 0);
    rst_n = 1'b1;
    idle_cycle();
    check("idle_busy", busy, 0);

    // ---- Nominal frame ----
    run_frame(0, NONE, NONE, NONE, s0, e0);
    check("nominal_busy_after_last", busy, 0);
    idle_cycle();
    idle_cycle();
    check("nominal_done_count", done_hist.size(), 1);
    if (done_hist.size() >= 1) check("nominal_done_latency", done_hist[0] - s0, 62);
    check("nominal_done_after_last_edge", (done_hist.size() >= 1) ? done_hist[0] : -1, e0);
    check("nominal_done_low_after", done, 0);
    check("nominal_matrix_errors", mat_errors(0), 0);
    for (int k = 0; k < 7; k++)
      check($sformatf("elem[%0d][%0d]", elem_tab[k].row, elem_tab[k].col),
            matrix_out[elem_tab[k].row][elem_tab[k].col], elem_tab[k].expected);

    // ---- Back-to-back frames A (=M) and B (=M+1000) ----
    done_hist.delete();
    run_frame(0, NONE, NONE, NONE, s0, e0);
    for (int t = 0; t <= LAST; t++) begin
      send_beat(t, 1000);
      if (t == 0) begin
        s1 = cyc;
        check("b2b_busy_at_B0", busy, 1);
      end
      if (t == 30) begin
        check("b2b_holds_A", mat_errors(0), 0);
        check("b2b_one_done_so_far", done_hist.size(), 1);
      end
    end
    e1 = cyc;
    idle_cycle();
    idle_cycle();
    check("b2b_done_count", done_hist.size(), 2);
    if (done_hist.size() == 2) check("b2b_done_spacing", done_hist[1] - done_hist[0], 63);
    check("b2b_B_start_no_bubble", s1 - e0, 1);
    check("b2b_B00", matrix_out[0][0], 1001);
    check("b2b_B_errors", mat_errors(1000), 0);
`ifdef MATRIX_COLLECTOR_FRAME_CNT_EN
    check("frame_cnt_after_3", frame_cnt, 3);
`endif

    // ---- Stalls after beats 10 and 40 ----
    done_hist.delete();
    run_frame(0, 10, 40, NONE, s0, e0);
    idle_cycle();
    check("stall_done_count", done_hist.size(), 1);
    if (done_hist.size() >= 1) check("stall_done_latency", done_hist[0] - s0, 68);
    check("stall_matrix_errors", mat_errors(0), 0);

    // ---- Enable gating with garbage data mid-frame ----
    done_hist.delete();
    run_frame(500, NONE, NONE, 30, s0, e0);
    idle_cycle();
    check("gate_done_count", done_hist.size(), 1);
    if (done_hist.size() >= 1) check("gate_done_latency", done_hist[0] - s0, 67);
    check("gate_matrix_errors", mat_errors(500), 0);

    // ---- Reset mid-frame at beat 20 ----
    done_hist.delete();
    for (int t = 0; t < 20; t++) send_beat(t, 0);
    check("midrst_busy_before", busy, 1);
    rst_n     = 1'b0;
    valid_in  = 1'b1;
    vector_in = beat_vec(20, 0);
    step();
    rst_n     = 1'b1;
    valid_in  = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_matrix_nonzero", nonzero_count(), 0);
`ifdef MATRIX_COLLECTOR_FRAME_CNT_EN
    check("frame_cnt_after_reset", frame_cnt, 0);
`endif
    nd = done_hist.size();
    run_frame(0, NONE, NONE, NONE, s0, e0);
    idle_cycle();
    check("fresh_done_count", done_hist.size() - nd, 1);
    if (done_hist.size() >= 1) check("fresh_done_latency", done_hist[done_hist.size()-1] - s0, 62);
    check("fresh_matrix_errors", mat_errors(0), 0);
`ifdef MATRIX_COLLECTOR_FRAME_CNT_EN
    check("frame_cnt_fresh", frame_cnt, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_collector.md
MATRIX_COLLECTOR -- requirements
Module: matrix_collector

Interface
REQ-001 Parameters SHALL be: N, default 32, matrix dimension; W, default 16, element width in bits.
REQ-002 Ports SHALL be exactly:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous active-low
- en  in  1  global enable; when low, all state holds
- valid_in  in  1  vector_in carries one skewed beat
- vector_in  in  [W-1:0] x N  skewed lane data; lane i is vector_in[i]
- busy  out  1  a frame is partially collected
- done  out  1  one-cycle pulse when matrix_out is updated
- matrix_out  out  [W-1:0] x N x N  last completed matrix, held stable

Function
REQ-003 One frame SHALL be 2N-1 accepted beats, t = 0..2N-2; a beat is accepted on a rising clk edge with rst_n=1, en=1 and valid_in=1.
REQ-004 On accepted beat t, for each lane i with 0 <= t-i <= N-1, the block SHALL write buf[t-i][i] = vector_in[i]; other lanes SHALL be ignored.
- This inverts the diagonal skew of the input feeder.
REQ-005 The FSM SHALL have states IDLE and COLLECT.
- IDLE to COLLECT on any accepted beat, which is beat t=0.
- COLLECT stays in COLLECT until beat t=2N-2 is accepted, then returns to IDLE.
REQ-006 The beat counter SHALL be ceil(log2(2N-1)) bits wide; it SHALL hold when no beat is accepted and SHALL clear to 0 after t=2N-2.
REQ-007 A cycle with valid_in=0 in COLLECT SHALL be a stall, not an abort: the counter and buf hold.
REQ-008 On acceptance of beat 2N-2, buf, including that beat's writes, SHALL be copied into matrix_out, with done=1 in the following cycle only.
- Latency: done is asserted 1 cycle after the final beat's edge.
REQ-009 matrix_out SHALL change only at frame completion; it SHALL stay stable during collection of the next frame.
REQ-010 Back-to-back frames SHALL be supported: a beat accepted in the cycle done=1 is t=0 of the next frame, with no bubble.
REQ-011 busy SHALL be 1 exactly while the state is COLLECT.
REQ-012 With en=0, no beat is accepted, state/counter/buf/matrix_out hold, and done is forced to 0.
REQ-013 Data SHALL pass unmodified: no arithmetic, no width change, W bits per element.

Reset
REQ-014 When rst_n=0 at a rising clk edge, the block SHALL go to IDLE, counter=0, busy=0, done=0, and every matrix_out element = 0; rst_n takes precedence over en.
REQ-015 buf SHALL need no reset, since every element is written before use.
REQ-016 Reset mid-frame SHALL discard the partial frame; the next accepted beat is t=0.

Configuration
REQ-017 If MATRIX_COLLECTOR_FRAME_CNT_EN is defined, the block SHALL add output frame_cnt [15:0].
- frame_cnt resets to 0.
- frame_cnt increments, wrapping 0xFFFF to 0, in the same cycle done rises.
REQ-018 If the macro is undefined, the port and the counter SHALL be absent; all other behaviour is identical.

Structure
REQ-019 A shared package SHALL hold the default N and W, the FSM state enum, and the beat-count width function.
- The same package is reused by the input-side feeder.
REQ-020 One sub-module, collector_ctrl, SHALL own the FSM, the beat counter and the done/busy generation; the datapath write and copy logic SHALL stay in the top level.

Verification
REQ-021 Nominal frame: source M[r][c] = r*32+c+1, skewed so lane i carries M[t-i][i] (else 0), 63 beats back-to-back.
- done pulses once, 1 cycle after beat 62.
- matrix_out[0][0]=1, [31][31]=1024, [5][7]=168.
REQ-022 Stalls: the same frame with valid_in=0 for 3 cycles after beats 10 and 40 gives an identical matrix_out; busy=1 throughout, and done occurs 6 cycles later than nominal.
REQ-023 Back-to-back frames: frame A = M, frame B = M+1000 with no gap between frames.
- done pulses twice, 63 cycles apart.
- matrix_out holds A until B completes; then [0][0]=1001.
REQ-024 Reset mid-frame: rst_n=0 for 1 cycle at beat 20.
- Immediately after reset: busy=0 and matrix_out all 0.
- A full fresh frame after reset then completes correctly.
REQ-025 Enable gating: en=0 for 5 cycles mid-frame while valid_in=1 with garbage data (0xDEAD); the result is unchanged and done is never asserted during en=0.
REQ-026 With MATRIX_COLLECTOR_FRAME_CNT_EN defined, 3 frames give frame_cnt=3; after reset, frame_cnt=0.
